// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared definitions for the byte-serialising memory sequencer.
//   - typeData encodings (byte / halfword / word; 2'b11 behaves as word)
//   - FSM state encoding
//   - default abort limit for a byte access that never gets MEM_ACK
//   - helpers: last byte index for a size, alignment check
package mem_seq_pkg;

    localparam logic [1:0] TD_BYTE = 2'b00;
    localparam logic [1:0] TD_HALF = 2'b01;
    localparam logic [1:0] TD_WORD = 2'b10;

    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_REARM  = 2'd3
    } state_t;

    // Index of the final byte of an item: N-1 for N = 1/2/4.
    function automatic logic [1:0] last_index(input logic [1:0] td);
        case (td)
            TD_BYTE: last_index = 2'd0;
            TD_HALF: last_index = 2'd1;
            default: last_index = 2'd3;
        endcase
    endfunction

    // Halfwords need an even address, words (and 2'b11) a multiple of four.
    function automatic logic misaligned(input logic [1:0] td, input logic [1:0] a);
        case (td)
            TD_BYTE: misaligned = 1'b0;
            TD_HALF: misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_seq_if.sv
// mem_seq_if: bundles the control-unit side (MOV/RW/typeData/ADDR/WDATA in,
// RDATA/MOC/ERR/BUSY out) and the byte-wide RAM side (MEM_ADDR/MEM_DOUT/
// MEM_EN/MEM_WE out, MEM_DIN/MEM_ACK in) of the sequencer.
//   slave  : seen by the sequencer itself
//   master : seen by the environment (control unit + RAM)
interface mem_seq_if
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic              MOV;
    logic              RW;
    logic [1:0]        typeData;
    logic [31:0]       ADDR;
    logic [31:0]       WDATA;
    logic [31:0]       RDATA;
    logic              MOC;
    logic              ERR;
    logic              BUSY;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [7:0]        MEM_DOUT;
    logic [7:0]        MEM_DIN;
    logic              MEM_EN;
    logic              MEM_WE;
    logic              MEM_ACK;

    modport slave (
        input  MOV, RW, typeData, ADDR, WDATA, MEM_DIN, MEM_ACK,
        output RDATA, MOC, ERR, BUSY, MEM_ADDR, MEM_DOUT, MEM_EN, MEM_WE
    );

    modport master (
        output MOV, RW, typeData, ADDR, WDATA, MEM_DIN, MEM_ACK,
        input  RDATA, MOC, ERR, BUSY, MEM_ADDR, MEM_DOUT, MEM_EN, MEM_WE
    );
endinterface

// File: rtl/mem_seq_timer.sv
// mem_seq_timer: loadable wait counter for one byte access.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : reload to zero (start of a byte / byte acknowledged)
//   count_en   : count one waiting cycle
//   expired    : high during the LIMIT-th waiting cycle, i.e. the last cycle
//                in which an acknowledge is still accepted
module mem_seq_timer
    import mem_seq_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/mem_seq.sv
// mem_seq: splits a byte/halfword/word transfer from the control unit into
// big-endian byte accesses on a byte-wide RAM with an EN/ACK handshake.
//   CLK      : system clock, rising edge
//   CLR      : asynchronous active-low reset
//   bus      : mem_seq_if.slave
//              control side - MOV, RW, typeData, ADDR, WDATA in;
//                             RDATA, MOC, ERR, BUSY out
//              RAM side     - MEM_ADDR, MEM_DOUT, MEM_EN, MEM_WE out;
//                             MEM_DIN, MEM_ACK in
// Misaligned requests finish at once with ERR; a byte that is not
// acknowledged within TIMEOUT cycles aborts the transfer with ERR.
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int ADDR_W  = 8
) (
    input  logic     CLK,
    input  logic     CLR,
    mem_seq_if.slave bus
);
    state_t            state, state_n;
    logic              rw_q;
    logic              err_q;
    logic [1:0]        last_q;
    logic [1:0]        k_q;
    logic [1:0]        byte_sel;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic [31:0]       rdata_q;
    logic              in_access;
    logic              req_bad;
    logic              last_byte;
    logic              tmo_hit;
    logic              tmr_clear;
    logic              unused_addr_hi;

    assign in_access = (state == ST_ACCESS);
    assign req_bad   = misaligned(bus.typeData, bus.ADDR[1:0]);
    assign last_byte = (k_q == last_q);
    // Big-endian: byte k of the item is byte (N-1-k) of the right-justified word.
    assign byte_sel  = last_q - k_q;
    // The wait count restarts for every byte and is idle outside ACCESS.
    assign tmr_clear = !in_access || bus.MEM_ACK;
    // Address bits above the RAM width are intentionally ignored.
    assign unused_addr_hi = ^bus.ADDR[31:ADDR_W];

    mem_seq_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (CLR),
        .clear   (tmr_clear),
        .count_en(in_access),
        .expired (tmo_hit)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (bus.MOV) begin
                    state_n = req_bad ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (bus.MEM_ACK) begin
                    if (last_byte) begin
                        state_n = ST_DONE;
                    end
                end else if (tmo_hit) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_REARM;
            end
            ST_REARM: begin
                // A MOV still held from the finished transfer must not restart.
                if (!bus.MOV) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 2'd0;
            k_q     <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.MOV) begin
                        rw_q    <= bus.RW;
                        err_q   <= req_bad;
                        last_q  <= last_index(bus.typeData);
                        k_q     <= 2'd0;
                        addr_q  <= bus.ADDR[ADDR_W-1:0];
                        wdata_q <= bus.WDATA;
                        asm_q   <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (bus.MEM_ACK) begin
                        asm_q <= {asm_q[23:0], bus.MEM_DIN};
                        k_q   <= k_q + 2'd1;
                        // Publish on the final byte so RDATA is valid alongside MOC.
                        if (last_byte && rw_q) begin
                            rdata_q <= {asm_q[23:0], bus.MEM_DIN};
                        end
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.RDATA    = rdata_q;
    assign bus.MOC      = (state == ST_DONE);
    assign bus.ERR      = (state == ST_DONE) && err_q;
    assign bus.BUSY     = (state != ST_IDLE);
    assign bus.MEM_EN   = in_access;
    assign bus.MEM_WE   = in_access && !rw_q;
    assign bus.MEM_ADDR = in_access ? (addr_q + ADDR_W'(k_q)) : '0;
    assign bus.MEM_DOUT = (in_access && !rw_q) ? wdata_q[{byte_sel, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: randomized and directed transfers against a transaction-level
// model. For every accepted MOV the model expands the request into the
// expected per-cycle RAM activity (address, write byte, handshake length)
// and the expected MOC/ERR/RDATA outcome; one compare process checks the
// design against that expectation on every falling edge.
module tb_mem_seq;
    import mem_seq_pkg::*;

    localparam int TMO = 15;
    localparam int AW  = 8;

    typedef struct {
        logic        en;
        logic [7:0]  addr;
        logic        we;
        logic [7:0]  dout;
        logic        commit;
        logic        moc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic clr;
    mem_seq_if #(.ADDR_W(AW)) bus ();

    mem_seq #(.TIMEOUT(TMO), .ADDR_W(AW)) dut (
        .CLK(clk),
        .CLR(clr),
        .bus(bus)
    );

    int          total;
    int          bad;
    exp_t        exp_q[$];
    logic [7:0]  ram[256];
    logic [7:0]  ref_ram[256];
    logic [31:0] rd_model;
    logic [31:0] rdata_cur;
    int          wait_cfg;
    logic        no_ack_cfg;
    logic        noise_en;
    logic        ack_r;
    int          r_lat, r_moc, r_en, r_en_after;
    logic        r_err;

    assign bus.MEM_ACK = ack_r;
    assign bus.MEM_DIN = ram[bus.MEM_ADDR];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Byte-wide RAM: answers after wait_cfg extra cycles, or never when
    // no_ack_cfg is set; raises stray acknowledges while not enabled.
    initial begin
        int wcnt;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
        wcnt  = 0;
        ack_r = 1'b0;
        forever begin
            @(negedge clk);
            if (!clr) begin
                wcnt  = 0;
                ack_r = 1'b0;
            end else if (bus.MEM_EN) begin
                if (!no_ack_cfg && wcnt == wait_cfg) begin
                    ack_r = 1'b1;
                    wcnt  = 0;
                    if (bus.MEM_WE) ram[bus.MEM_ADDR] = bus.MEM_DOUT;
                end else begin
                    ack_r = 1'b0;
                    wcnt++;
                end
            end else begin
                ack_r = noise_en & 1'($urandom);
                wcnt  = 0;
            end
        end
    end

    // Compare process: one expected entry per cycle of an active transfer,
    // otherwise the RAM side must be quiet and MOC/ERR low.
    initial begin
        exp_t e;
        for (int i = 0; i < 256; i++) ref_ram[i] = 8'(i) ^ 8'h5A;
        rdata_cur = 32'h0;
        forever begin
            @(negedge clk);
            if (!clr) begin
                rdata_cur = 32'h0;
            end else begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("busy", 32'(bus.BUSY), 32'd1);
                    chk("mem_en", 32'(bus.MEM_EN), 32'(e.en));
                    chk("moc", 32'(bus.MOC), 32'(e.moc));
                    chk("err", 32'(bus.ERR), 32'(e.err));
                    if (e.en) begin
                        chk("mem_addr", 32'(bus.MEM_ADDR), 32'(e.addr));
                        chk("mem_we", 32'(bus.MEM_WE), 32'(e.we));
                        if (e.we) chk("mem_dout", 32'(bus.MEM_DOUT), 32'(e.dout));
                    end
                    if (e.commit) ref_ram[e.addr] = e.dout;
                    rdata_cur = e.rdata;
                end else begin
                    chk("quiet_en", 32'(bus.MEM_EN), 32'd0);
                    chk("quiet_moc", 32'(bus.MOC), 32'd0);
                    chk("quiet_err", 32'(bus.ERR), 32'd0);
                end
                chk("rdata", bus.RDATA, rdata_cur);
            end
        end
    end

    // Transaction-level model: expand one accepted request into per-cycle
    // expectations from the size, alignment, RAM latency and byte order rules.
    task automatic build(input logic rw, input logic [1:0] td, input logic [31:0] addr,
                         input logic [31:0] wd, input int wt, input logic noack);
        exp_t        e;
        int          n;
        logic        mis;
        logic        ok;
        logic [31:0] val;
        logic [7:0]  ba;
        n   = (td == 2'b00) ? 1 : (td == 2'b01) ? 2 : 4;
        mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
        ok  = !mis;
        val = 32'h0;
        e.en = 0; e.addr = 0; e.we = 0; e.dout = 0; e.commit = 0;
        e.moc = 0; e.err = 0; e.rdata = rd_model;
        if (!mis) begin
            for (int i = 0; i < n; i++) begin
                ba     = 8'(addr[7:0] + 8'(i));
                e.en   = 1'b1;
                e.addr = ba;
                e.we   = !rw;
                e.dout = 8'(wd >> (8 * (n - 1 - i)));
                if (noack) begin
                    e.commit = 1'b0;
                    for (int c = 0; c < TMO; c++) exp_q.push_back(e);
                    ok = 1'b0;
                    break;
                end
                for (int c = 0; c <= wt; c++) begin
                    e.commit = !rw && (c == wt);
                    exp_q.push_back(e);
                end
                val = (val << 8) | 32'(ref_ram[ba]);
            end
        end
        if (ok && rw) rd_model = val;
        e.en = 0; e.we = 0; e.commit = 0; e.moc = 1; e.err = !ok; e.rdata = rd_model;
        exp_q.push_back(e);
    endtask

    task automatic xfer(input logic rw, input logic [1:0] td, input logic [31:0] addr,
                        input logic [31:0] wd, input int wt, input logic noack,
                        input int hold, input int rst_at);
        bit seen;
        int h;
        int n;
        wait_cfg   = wt;
        no_ack_cfg = noack;
        @(posedge clk);
        #1;
        bus.MOV = 1'b1; bus.RW = rw; bus.typeData = td; bus.ADDR = addr; bus.WDATA = wd;
        @(posedge clk);
        build(rw, td, addr, wd, wt, noack);
        #1;
        if (hold == 0) bus.MOV = 1'b0;
        // Request inputs changing mid-transfer must have no effect.
        bus.RW = 1'($urandom); bus.typeData = 2'($urandom);
        bus.ADDR = $urandom; bus.WDATA = $urandom;
        r_lat = 0; r_moc = 0; r_en = 0; r_en_after = 0; r_err = 1'b0;
        seen = 0;
        h = hold;
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == rst_at) begin
                #2 clr = 1'b0;
                #1;
                chk("arst_rdata", bus.RDATA, 32'h0);
                chk("arst_moc", 32'(bus.MOC), 32'd0);
                chk("arst_err", 32'(bus.ERR), 32'd0);
                chk("arst_busy", 32'(bus.BUSY), 32'd0);
                chk("arst_en", 32'(bus.MEM_EN), 32'd0);
                chk("arst_we", 32'(bus.MEM_WE), 32'd0);
                chk("arst_addr", 32'(bus.MEM_ADDR), 32'd0);
                chk("arst_dout", 32'(bus.MEM_DOUT), 32'd0);
                exp_q.delete();
                rd_model = 32'h0;
                @(negedge clk);
                #1 clr = 1'b1;
                return;
            end
            if (bus.MEM_EN) begin
                r_en++;
                if (seen) r_en_after++;
            end
            if (bus.MOC) begin
                r_moc++;
                if (!seen) r_lat = n;
                seen = 1;
                if (bus.ERR) r_err = 1'b1;
            end
            if (seen && bus.MOV) begin
                if (h > 0) h--;
                if (h == 0) bus.MOV = 1'b0;
            end
            if (seen && !bus.MOV && !bus.BUSY) break;
        end
        if (n > 200) begin
            total++;
            bad++;
            $display("FAIL xfer_idle: no return to idle within 200 cycles, moc_seen=%0d busy=%0b", seen, bus.BUSY);
            exp_q.delete();
            bus.MOV = 1'b0;
        end
    endtask

    initial begin
        logic [1:0]  td;
        logic [31:0] a;
        total = 0; bad = 0;
        rd_model = 32'h0;
        wait_cfg = 0; no_ack_cfg = 1'b0; noise_en = 1'b0;
        clr = 1'b0;
        bus.MOV = 1'b0; bus.RW = 1'b0; bus.typeData = 2'b00;
        bus.ADDR = 32'h0; bus.WDATA = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", bus.RDATA, 32'h0);
        chk("rst_moc", 32'(bus.MOC), 32'd0);
        chk("rst_err", 32'(bus.ERR), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_en", 32'(bus.MEM_EN), 32'd0);
        chk("rst_addr", 32'(bus.MEM_ADDR), 32'd0);
        clr = 1'b1;
        noise_en = 1'b1;

        // Word read at 0x04 with zero-wait RAM, after loading the bytes.
        xfer(1'b0, TD_WORD, 32'h04, 32'h11223344, 0, 1'b0, 0, -1);
        xfer(1'b1, TD_WORD, 32'h04, 32'hFFFF_FFFF, 0, 1'b0, 0, -1);
        chk("w_rd_lat", 32'(r_lat), 32'd5);
        chk("w_rd_data", bus.RDATA, 32'h11223344);
        chk("w_rd_err", 32'(r_err), 32'd0);

        // Halfword write with two wait states per byte.
        xfer(1'b0, TD_HALF, 32'h06, 32'h0000ABCD, 2, 1'b0, 0, -1);
        chk("h_wr_ram6", 32'(ram[6]), 32'hAB);
        chk("h_wr_ram7", 32'(ram[7]), 32'hCD);
        chk("h_wr_ram5", 32'(ram[5]), 32'h22);
        chk("h_wr_ram8", 32'(ram[8]), 32'h52);
        chk("h_wr_moc", 32'(r_moc), 32'd1);

        // Misaligned word read.
        xfer(1'b1, TD_WORD, 32'h02, 32'h0, 0, 1'b0, 0, -1);
        chk("mis_lat", 32'(r_lat), 32'd1);
        chk("mis_err", 32'(r_err), 32'd1);
        chk("mis_en", 32'(r_en), 32'd0);
        chk("mis_rdata", bus.RDATA, 32'h11223344);

        // Top of the address space: byte at 0xFF, word at 0xFC.
        xfer(1'b1, TD_BYTE, 32'hFF, 32'h0, 1, 1'b0, 0, -1);
        chk("b_ff_data", bus.RDATA, 32'h000000A5);
        xfer(1'b1, TD_WORD, 32'h1FC, 32'h0, 0, 1'b0, 0, -1);
        chk("w_fc_data", bus.RDATA, 32'hA6A7A4A5);
        chk("w_fc_err", 32'(r_err), 32'd0);

        // RAM never acknowledges; MOV held well past completion.
        xfer(1'b1, TD_WORD, 32'h20, 32'h0, 0, 1'b1, 6, -1);
        chk("tmo_lat", 32'(r_lat), 32'd16);
        chk("tmo_err", 32'(r_err), 32'd1);
        chk("tmo_en_cycles", 32'(r_en), 32'd15);
        chk("tmo_en_after", 32'(r_en_after), 32'd0);
        chk("tmo_rdata", bus.RDATA, 32'hA6A7A4A5);

        // Reset during the third byte of a word write, then a byte read.
        xfer(1'b0, TD_WORD, 32'h10, 32'hDEADBEEF, 1, 1'b0, 0, 5);
        chk("arst_ram10", 32'(ram[8'h10]), 32'hDE);
        chk("arst_ram12", 32'(ram[8'h12]), 32'h48);
        chk("arst_ram13", 32'(ram[8'h13]), 32'h49);
        xfer(1'b1, TD_BYTE, 32'h11, 32'h0, 0, 1'b0, 0, -1);
        chk("arst_rd", bus.RDATA, 32'h000000AD);
        chk("arst_rd_err", 32'(r_err), 32'd0);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            td = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            xfer(1'($urandom), td, a, $urandom, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), -1);
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) chk("ram_image", 32'(ram[i]), 32'(ref_ram[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 Parameter TIMEOUT, default 15, max cycles ACCESS waits for MEM_ACK on one byte before abort.
REQ-002 Parameter ADDR_W, default 8, byte-memory address width.
REQ-003 CLK  in  1  single system clock, all state on rising edge.
REQ-004 CLR  in  1  reset, asynchronous, active-low.
REQ-005 MOV  in  1  transfer request from control unit.
REQ-006 RW  in  1  1 = read, 0 = write.
REQ-007 typeData  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 ADDR  in  32  byte address from MAR; low ADDR_W bits used.
REQ-009 WDATA  in  32  write data from MDR; right-justified for byte/halfword.
REQ-010 RDATA  out  32  assembled read data, zero-extended.
REQ-011 MOC  out  1  one-cycle completion pulse to control unit.
REQ-012 ERR  out  1  one-cycle pulse coincident with MOC on misalign or timeout.
REQ-013 BUSY  out  1  high in every state except IDLE.
REQ-014 MEM_ADDR  out  ADDR_W  byte address to byte-wide RAM.
REQ-015 MEM_DOUT  out  8  write byte to RAM.
REQ-016 MEM_DIN  in  8  read byte from RAM.
REQ-017 MEM_EN  out  1  byte-access strobe, held until MEM_ACK.
REQ-018 MEM_WE  out  1  byte write enable, valid while MEM_EN high.
REQ-019 MEM_ACK  in  1  byte-access complete; read byte valid same cycle.

Function
REQ-020 FSM states IDLE, ACCESS, DONE, REARM.
REQ-021 IDLE: MOV=1 latches RW, typeData, ADDR, WDATA; byte count N = 1/2/4; byte index k cleared.
REQ-022 IDLE: misaligned request (halfword ADDR[0]=1; word ADDR[1:0]!=0) skips ACCESS, goes DONE with ERR=1, no MEM_EN, RDATA unchanged.
REQ-023 ACCESS: MEM_EN=1, MEM_ADDR=latched address+k (modulo 2^ADDR_W), MEM_WE=~RW.
REQ-024 Byte order big-endian: k=0 is most-significant byte of the N-byte item.
REQ-025 Write: MEM_DOUT = byte (N-1-k) of WDATA.
REQ-026 Read: on MEM_ACK, MEM_DIN shifted into assembly register (reg = reg<<8 | MEM_DIN), upper bytes zero.
REQ-027 MEM_ACK in ACCESS: k increments; k = N-1 -> DONE, else stay ACCESS with next address next cycle.
REQ-028 Zero-wait memory (ACK same cycle as EN): word completes with MOC 5 cycles after the MOV-sampling edge.
REQ-029 Wait counter clears on each ACK; reaching TIMEOUT without ACK -> DONE with ERR=1, MEM_EN dropped, RDATA unchanged.
REQ-030 DONE: MOC=1 one cycle; RDATA updated from assembly register on successful read, held until next successful read; writes leave RDATA unchanged.
REQ-031 DONE -> REARM; REARM waits for MOV=0, then IDLE; a held MOV never starts a second transfer.
REQ-032 MOV, RW, typeData, ADDR, WDATA changes outside IDLE are ignored.
REQ-033 MEM_ACK outside ACCESS is ignored.

Reset
REQ-034 CLR low at any time, including mid-ACCESS, forces IDLE immediately; RDATA=0, MOC=0, ERR=0, BUSY=0, MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_DOUT=0, counters 0.
REQ-035 No partial write is retried after reset; first transfer needs fresh MOV sampled in IDLE.

Structure
REQ-036 Shared package holds typeData encodings (BYTE, HALF, WORD), FSM state encoding, default TIMEOUT.
REQ-037 One sub-module natural: mem_seq_timer (loadable wait counter with expiry flag).

Verification
REQ-038 Word read at 0x04, RAM bytes 0x11,0x22,0x33,0x44, zero-wait -> RDATA=0x11223344, MOC 5 cycles after MOV, ERR=0.
REQ-039 Halfword write 0xABCD to 0x06, ACK after 2 waits per byte -> RAM[6]=0xAB, RAM[7]=0xCD, MOC once, RAM[5], RAM[8] untouched.
REQ-040 Word read at 0x02 -> MOC+ERR next cycle, MEM_EN never high, RDATA unchanged.
REQ-041 Byte read at 0xFF, ADDR_W=8, then word read at 0xFC -> byte zero-extended; addresses 0xFC..0xFF, no wrap error.
REQ-042 MEM_ACK never returned -> ERR+MOC after 15 wait cycles; MOV held high afterwards -> no new MEM_EN until MOV low.
REQ-043 CLR low during byte 2 of word write -> all outputs reset within same cycle; subsequent byte read completes normally.
